// File: rtl/tone_pkg.sv
// Shared types and constants for the tone player and related audio blocks.
package tone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } env_state_t;

  localparam int NUM_TONES  = 19;
  localparam int HALF_PER_W = 17;

  // First note index that is treated as silence.
  localparam logic [4:0] SILENT_MIN = 5'd19;

  // Half-periods in 50 MHz clocks: round(25e6 / (261.626 * 2^(i/12))), C4..F#5.
  localparam logic [HALF_PER_W-1:0] HALF_PER [0:NUM_TONES-1] = '{
    17'd95556, 17'd90193, 17'd85131, 17'd80353, 17'd75843,
    17'd71586, 17'd67568, 17'd63776, 17'd60197, 17'd56818,
    17'd53629, 17'd50619, 17'd47778, 17'd45097, 17'd42565,
    17'd40176, 17'd37922, 17'd35793, 17'd33784
  };

endpackage

// File: rtl/tone_table.sv
// Combinational note-index to half-period ROM; indices past the table read 0.
module tone_table
  import tone_pkg::*;
(
  input  logic [4:0]            idx_i,
  output logic [HALF_PER_W-1:0] half_per_o
);

  // Look up the half-period, returning 0 for silent indices
  always_comb begin
    half_per_o = {HALF_PER_W{1'b0}};
    if (idx_i < SILENT_MIN) begin
      half_per_o = HALF_PER[idx_i];
    end else begin
      half_per_o = {HALF_PER_W{1'b0}};
    end
  end

endmodule

// File: rtl/tone_player.sv
// Square-wave tone generator with attack/sustain/release envelope and a
// fixed-rate signed sample stream for the codec plus a raw buzzer output.
module tone_player
  import tone_pkg::*;
#(
  parameter int         SAMPLE_DIV = 1042,
  parameter logic [7:0] ENV_STEP   = 8'd4,
  parameter logic [7:0] LEVEL_MAX  = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [4:0]  tone,
  output logic [15:0] audio_sample,
  output logic        sample_valid,
  output logic        square_out,
  output logic        busy
);

  localparam int                SDIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [SDIV_W-1:0] SDIV_LAST = SDIV_W'(SAMPLE_DIV - 1);

  env_state_t            state_q, state_d;
  logic [SDIV_W-1:0]     sdiv_q, sdiv_d;
  logic [HALF_PER_W-1:0] pcnt_q, pcnt_d;
  logic                  square_q, square_d;
  logic [4:0]            cur_tone_q, cur_tone_d;
  logic [7:0]            level_q, level_d;
  logic [15:0]           audio_q, audio_d;
  logic                  valid_q, valid_d;

  logic                  tone_ok_s;
  logic                  active_s;
  logic                  tick_s;
  logic [4:0]            tone_idx_s;
  logic [HALF_PER_W-1:0] half_per_s;
  logic [8:0]            lvl_sum_s;
  logic [7:0]            lvl_up_s;
  logic [7:0]            lvl_dn_s;
  logic [15:0]           mag_s;
  logic [15:0]           sample_s;

  assign tone_ok_s = (tone < SILENT_MIN);
  assign active_s  = enable && tone_ok_s;
  assign tick_s    = (sdiv_q == SDIV_LAST);

  // An invalid tone on an edge keeps the previous note's period running
  assign tone_idx_s = tone_ok_s ? tone : cur_tone_q;

  tone_table u_table (
    .idx_i      (tone_idx_s),
    .half_per_o (half_per_s)
  );

  // Saturating envelope steps
  assign lvl_sum_s = {1'b0, level_q} + {1'b0, ENV_STEP};
  assign lvl_up_s  = (lvl_sum_s > {1'b0, LEVEL_MAX}) ? LEVEL_MAX : lvl_sum_s[7:0];
  assign lvl_dn_s  = (level_q >= ENV_STEP) ? (level_q - ENV_STEP) : 8'd0;

  // Sample is built from the post-update level and square so it lines up
  // with square_out in the cycle sample_valid is high
  assign mag_s    = {2'b00, level_d, 6'b000000};
  assign sample_s = square_d ? mag_s : (16'd0 - mag_s);

  // Next-state logic: sample divider, oscillator, envelope FSM, sample register
  always_comb begin
    state_d    = state_q;
    sdiv_d     = sdiv_q;
    pcnt_d     = pcnt_q;
    square_d   = square_q;
    cur_tone_d = cur_tone_q;
    level_d    = level_q;
    audio_d    = audio_q;
    valid_d    = 1'b0;

    if (tick_s) begin
      sdiv_d = {SDIV_W{1'b0}};
    end else begin
      sdiv_d = sdiv_q + {{(SDIV_W-1){1'b0}}, 1'b1};
    end

    if (state_q != ST_IDLE) begin
      if (pcnt_q == {HALF_PER_W{1'b0}}) begin
        square_d   = ~square_q;
        cur_tone_d = tone_idx_s;
        pcnt_d     = half_per_s - 17'd1;
      end else begin
        pcnt_d = pcnt_q - 17'd1;
      end
    end else begin
      pcnt_d = pcnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (active_s) begin
          state_d    = ST_ATTACK;
          cur_tone_d = tone;
          square_d   = 1'b0;
          pcnt_d     = half_per_s - 17'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ATTACK: begin
        if (!active_s) begin
          state_d = ST_RELEASE;
        end else if (tick_s) begin
          level_d = lvl_up_s;
          if (lvl_up_s == LEVEL_MAX) begin
            state_d = ST_SUSTAIN;
          end else begin
            state_d = ST_ATTACK;
          end
        end else begin
          state_d = ST_ATTACK;
        end
      end
      ST_SUSTAIN: begin
        if (!active_s) begin
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_SUSTAIN;
        end
      end
      ST_RELEASE: begin
        if (active_s) begin
          state_d = ST_ATTACK;
        end else if (tick_s) begin
          level_d = lvl_dn_s;
          if (lvl_dn_s == 8'd0) begin
            state_d  = ST_IDLE;
            square_d = 1'b0;
            pcnt_d   = {HALF_PER_W{1'b0}};
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          state_d = ST_RELEASE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        level_d  = 8'd0;
        square_d = 1'b0;
        pcnt_d   = {HALF_PER_W{1'b0}};
      end
    endcase

    if (tick_s) begin
      valid_d = 1'b1;
      if (state_d == ST_IDLE) begin
        audio_d = 16'd0;
      end else begin
        audio_d = sample_s;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sdiv_q     <= {SDIV_W{1'b0}};
      pcnt_q     <= {HALF_PER_W{1'b0}};
      square_q   <= 1'b0;
      cur_tone_q <= 5'd0;
      level_q    <= 8'd0;
      audio_q    <= 16'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sdiv_q     <= sdiv_d;
      pcnt_q     <= pcnt_d;
      square_q   <= square_d;
      cur_tone_q <= cur_tone_d;
      level_q    <= level_d;
      audio_q    <= audio_d;
      valid_q    <= valid_d;
    end
  end

  assign audio_sample = audio_q;
  assign sample_valid = valid_q;
  assign square_out   = (state_q != ST_IDLE) ? square_q : 1'b0;
  assign busy         = (state_q != ST_IDLE);

endmodule
